cambricon_tile_scheduler: RTL and testbench
===========================================

// Module: cambricon_tile_scheduler
// PURPOSE
//  Sequences the PE array and SFU over a job of num_tiles INPUT_SIZE-element tiles.
//  Per tile: request operand load, start PE array, latch its overflow (outlier) bitmap,
//  then dispatch each flagged element index to the SFU, lowest index first.
//  Sits between the host command interface and the PE_array/SFU datapath pair.
// PARAMETERS
//  INPUT_SIZE   128   elements per tile; width of outlier bitmap
//  TILE_W       8     width of num_tiles / tile index (max 2**TILE_W-1 tiles)
//  PE_TIMEOUT   1024  cycles allowed between pe_start and pe_done before error
//  IDX_W        $clog2(INPUT_SIZE)  element-index width (derived, not overridden)
// PORTS
//  clk          in   1           single clock, all state on posedge
//  rst          in   1           synchronous, active-high reset
//  start        in   1           job start pulse; sampled only in IDLE
//  num_tiles    in   TILE_W      tile count, latched on accepted start
//  busy         out  1           high from accepted start until done
//  done         out  1           one-cycle pulse at job end
//  error        out  1           sticky PE timeout flag; cleared by next accepted start
//  ld_req       out  1           operand load request, held until ld_done
//  ld_tile      out  TILE_W      tile index to load
//  ld_done      in   1           loader finished tile ld_tile
//  pe_start     out  1           one-cycle PE array start pulse
//  pe_done      in   1           PE array result valid (one-cycle pulse)
//  pe_outliers  in   INPUT_SIZE  overflow bitmap; valid in the pe_done cycle
//  sfu_valid    out  1           outlier dispatch valid
//  sfu_ready    in   1           SFU accepts dispatch
//  sfu_idx      out  IDX_W       element index of outlier
//  sfu_tile     out  TILE_W      tile index of outlier
//  outlier_cnt  out  16          outliers dispatched in current job, saturating
// BEHAVIOUR
//  Reset: state IDLE; busy, done, error, ld_req, pe_start, sfu_valid = 0;
//   ld_tile, sfu_idx, sfu_tile, outlier_cnt = 0; mask = 0.
//  FSM: IDLE -> LOAD -> COMPUTE -> DISPATCH -> (LOAD | FINISH) -> IDLE.
//  IDLE: start=1 latches num_tiles, clears error/outlier_cnt, tile=0, busy=1.
//   If num_tiles==0 -> FINISH directly. start outside IDLE is ignored.
//  LOAD: ld_req=1, ld_tile=tile; ld_done=1 -> COMPUTE, ld_req drops next cycle.
//  COMPUTE: pe_start pulses 1 cycle on entry; timer counts; pe_done=1 latches
//   pe_outliers into mask -> DISPATCH. Timer reaching PE_TIMEOUT-1 without pe_done
//   -> error=1, FINISH (remaining tiles abandoned). pe_done outside COMPUTE ignored.
//  DISPATCH: sfu_idx = lowest set bit of mask; sfu_valid = (mask!=0).
//   sfu_idx/sfu_tile stable while sfu_valid && !sfu_ready (AXI-style, no retraction).
//   Handshake clears that bit; next index presented the following cycle
//   (back-to-back throughput 1/cycle). outlier_cnt += 1, saturates at 16'hFFFF.
//   mask==0 (incl. empty bitmap on entry): tile==num_tiles-1 -> FINISH,
//   else tile+=1 -> LOAD. Empty tile spends exactly 1 cycle in DISPATCH.
//  FINISH: done=1 for one cycle, busy=0 same cycle -> IDLE; outlier_cnt, error held.
//  rst mid-job: all state returns to reset values next edge, no done pulse.
//  Widths: tile counter TILE_W unsigned, compare vs num_tiles-1 computed on latched value.
// STRUCTURE
//  Package cambricon_sched_pkg: state_t enum {IDLE,LOAD,COMPUTE,DISPATCH,FINISH},
//   OUTLIER_CNT_W=16 constant.
//  Sub-module lsb_index_enc #(INPUT_SIZE): combinational lowest-set-bit index + any flag.
//  Top: FSM, tile counter, timeout counter, mask register, outlier counter.
// TESTING
//  1 num_tiles=3, bitmaps all 0, ld_done/pe_done 2 cycles after req -> 3 ld_req, 3 pe_start,
//    0 sfu_valid, done pulse, outlier_cnt=0.
//  2 num_tiles=1, bitmap bits {5,0,127}, sfu_ready=1 -> sfu_idx 0,5,127 on consecutive
//    cycles, outlier_cnt=3, done.
//  3 bitmap bit 9, sfu_ready low 4 cycles -> sfu_valid, sfu_idx=9 held stable 5 cycles, 1 transfer.
//  4 pe_done never asserted -> error=1 at PE_TIMEOUT cycles after pe_start, done pulse, busy=0.
//  5 num_tiles=0 -> done 1 cycle after start, no ld_req; start while busy -> ignored.
//  6 rst asserted during DISPATCH -> next cycle all outputs at reset values, no done.

Source files
------------

// File: rtl/cambricon_tile_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// cambricon_sched_pkg
//   Shared types and constants for the tile scheduler.
//   state_t        : scheduler FSM states
//   OUTLIER_CNT_W  : width of the per-job outlier counter
//   sat_inc()      : saturating increment for the outlier counter
// ---------------------------------------------------------------------------
package cambricon_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        COMPUTE  = 3'd2,
        DISPATCH = 3'd3,
        FINISH   = 3'd4
    } state_t;

    localparam int OUTLIER_CNT_W = 16;

    // Counter sticks at all-ones rather than wrapping back to zero.
    function automatic logic [OUTLIER_CNT_W-1:0] sat_inc(
        input logic [OUTLIER_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cambricon_tile_scheduler_lsb_index_enc.sv
// ---------------------------------------------------------------------------
// lsb_index_enc
//   Combinational lowest-set-bit encoder.
//   i_vec  in  INPUT_SIZE  bit vector to scan
//   o_idx  out IDX_W       index of the lowest set bit (0 when i_vec == 0)
//   o_any  out 1           any bit of i_vec set
// ---------------------------------------------------------------------------
module lsb_index_enc #(
    parameter  int INPUT_SIZE = 128,
    localparam int IDX_W      = $clog2(INPUT_SIZE)
) (
    input  logic [INPUT_SIZE-1:0] i_vec,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_any
);

    // Scan from the top down so the last hit (the lowest index) wins.
    always_comb begin
        o_idx = '0;
        for (int k = INPUT_SIZE - 1; k >= 0; k--) begin
            if (i_vec[k]) begin
                o_idx = IDX_W'(k);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/cambricon_tile_scheduler.sv
// ---------------------------------------------------------------------------
// cambricon_tile_scheduler
//   Walks a job of num_tiles tiles through load -> PE compute -> outlier
//   dispatch.  For every tile the PE overflow bitmap is latched and each set
//   bit is handed to the SFU, lowest index first, one per handshake.
//
//   clk, rst             clock; synchronous active-high reset
//   start, num_tiles     job start pulse (IDLE only) and tile count
//   busy, done, error    job status; error is a sticky PE timeout flag
//   ld_req/ld_tile/ld_done           operand loader handshake
//   pe_start/pe_done/pe_outliers     PE array start and result bitmap
//   sfu_valid/sfu_ready/sfu_idx/sfu_tile   outlier dispatch (valid/ready)
//   outlier_cnt          saturating count of outliers dispatched this job
// ---------------------------------------------------------------------------
module cambricon_tile_scheduler
    import cambricon_sched_pkg::*;
#(
    parameter  int INPUT_SIZE = 128,
    parameter  int TILE_W     = 8,
    parameter  int PE_TIMEOUT = 1024,
    localparam int IDX_W      = $clog2(INPUT_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    // host command
    input  logic                     start,
    input  logic [TILE_W-1:0]        num_tiles,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    // operand loader
    output logic                     ld_req,
    output logic [TILE_W-1:0]        ld_tile,
    input  logic                     ld_done,
    // PE array
    output logic                     pe_start,
    input  logic                     pe_done,
    input  logic [INPUT_SIZE-1:0]    pe_outliers,
    // SFU dispatch
    output logic                     sfu_valid,
    input  logic                     sfu_ready,
    output logic [IDX_W-1:0]         sfu_idx,
    output logic [TILE_W-1:0]        sfu_tile,
    output logic [OUTLIER_CNT_W-1:0] outlier_cnt
);

    localparam int TMR_W = (PE_TIMEOUT > 1) ? $clog2(PE_TIMEOUT) : 1;

    state_t                   r_state;
    state_t                   w_next;
    logic [TILE_W-1:0]        r_num;
    logic [TILE_W-1:0]        r_tile;
    logic [TMR_W-1:0]         r_tmr;
    logic [INPUT_SIZE-1:0]    r_mask;
    logic                     r_error;
    logic [OUTLIER_CNT_W-1:0] r_cnt;

    logic [IDX_W-1:0]         w_idx;
    logic                     w_any;
    logic                     w_last;
    logic                     w_tmo;

    lsb_index_enc #(
        .INPUT_SIZE (INPUT_SIZE)
    ) u_enc (
        .i_vec (r_mask),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // r_num is never zero outside IDLE/FINISH, so the subtract cannot wrap
    // while the comparison matters.
    assign w_last = (r_tile == r_num - 1'b1);
    assign w_tmo  = (r_tmr == TMR_W'(PE_TIMEOUT - 1));

    // ---------------- next state ----------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (num_tiles == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                if (ld_done) begin
                    w_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (pe_done) begin
                    w_next = DISPATCH;
                end else if (w_tmo) begin
                    w_next = FINISH;
                end
            end
            DISPATCH: begin
                if (!w_any) begin
                    w_next = w_last ? FINISH : LOAD;
                end
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ---------------- outputs (decoded from registered state) ----------------
    always_comb begin
        busy        = (r_state == LOAD) || (r_state == COMPUTE) || (r_state == DISPATCH);
        done        = (r_state == FINISH);
        error       = r_error;
        ld_req      = (r_state == LOAD);
        ld_tile     = r_tile;
        // Timer is held at zero outside COMPUTE, so zero here marks the entry cycle.
        pe_start    = (r_state == COMPUTE) && (r_tmr == '0);
        sfu_valid   = (r_state == DISPATCH) && w_any;
        sfu_idx     = w_idx;
        sfu_tile    = r_tile;
        outlier_cnt = r_cnt;
    end

    // ---------------- state and datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_tile  <= '0;
            r_tmr   <= '0;
            r_mask  <= '0;
            r_error <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == COMPUTE) begin
                r_tmr <= r_tmr + 1'b1;
            end else begin
                r_tmr <= '0;
            end

            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num   <= num_tiles;
                        r_tile  <= '0;
                        r_error <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                COMPUTE: begin
                    if (pe_done) begin
                        r_mask <= pe_outliers;
                    end else if (w_tmo) begin
                        r_error <= 1'b1;
                    end
                end
                DISPATCH: begin
                    if (w_any) begin
                        if (sfu_ready) begin
                            // x & (x-1) drops exactly the lowest set bit,
                            // which is the index currently presented.
                            r_mask <= r_mask & (r_mask - 1'b1);
                            r_cnt  <= sat_inc(r_cnt);
                        end
                    end else if (!w_last) begin
                        r_tile <= r_tile + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cambricon_tile_scheduler.sv
module tb_cambricon_tile_scheduler;
    localparam int IS = 128;
    localparam int TW = 8;
    localparam int TO = 1024;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [TW-1:0] num_tiles;
    logic          busy, done, error;
    logic          ld_req, ld_done;
    logic [TW-1:0] ld_tile;
    logic          pe_start, pe_done;
    logic [IS-1:0] pe_outliers;
    logic          sfu_valid, sfu_ready;
    logic [IW-1:0] sfu_idx;
    logic [TW-1:0] sfu_tile;
    logic [15:0]   outlier_cnt;

    always #5 clk = ~clk;

    cambricon_tile_scheduler #(.INPUT_SIZE(IS), .TILE_W(TW), .PE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .busy(busy), .done(done), .error(error),
        .ld_req(ld_req), .ld_tile(ld_tile), .ld_done(ld_done),
        .pe_start(pe_start), .pe_done(pe_done), .pe_outliers(pe_outliers),
        .sfu_valid(sfu_valid), .sfu_ready(sfu_ready), .sfu_idx(sfu_idx),
        .sfu_tile(sfu_tile), .outlier_cnt(outlier_cnt)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_ld, n_pe, n_vld, n_done, pe_cyc, err_cyc;
    int ld_delay = 2, pe_delay = 2, rdy_pct = 100, rdy_low = 0;
    bit pe_hang = 0;
    logic [IS-1:0] bm [256];
    logic [TW+IW-1:0] obsq[$], expq[$];
    int xcyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // loader, PE array and SFU stand-ins; inputs change just after posedge
    initial begin
        int ldw, pew;
        bit arm;
        logic [TW-1:0] pt;
        ldw = 0; pew = 0; arm = 0; pt = '0;
        ld_done = 0; pe_done = 0; pe_outliers = '0; sfu_ready = 0;
        forever begin
            @(posedge clk); #1;
            ld_done = 0; pe_done = 0; pe_outliers = '0;
            if (ld_req) begin
                if (ldw >= ld_delay) begin ld_done = 1; ldw = 0; end
                else ldw++;
            end else ldw = 0;
            if (pe_start && !pe_hang) begin arm = 1; pew = pe_delay; pt = ld_tile; end
            if (arm) begin
                if (pew == 0) begin pe_done = 1; pe_outliers = bm[pt]; arm = 0; end
                else pew--;
            end
            if (rdy_low > 0) begin
                sfu_ready = 0;
                if (sfu_valid) rdy_low--;
            end else sfu_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // mid-cycle monitor: counts events, records transfers, checks hold rule
    initial begin
        logic ph, pld, prst, perr;
        logic [IW-1:0] pi;
        logic [TW-1:0] ptl;
        ph = 0; pld = 0; prst = 1; perr = 0; pi = '0; ptl = '0;
        forever begin
            @(negedge clk);
            if (ph && !prst) begin
                chk("hold_vld", sfu_valid, 1);
                chk("hold_idx", sfu_idx, pi);
                chk("hold_tile", sfu_tile, ptl);
            end
            if (sfu_valid) n_vld++;
            if (sfu_valid && sfu_ready) begin
                obsq.push_back({sfu_tile, sfu_idx});
                xcyc.push_back(cyc);
            end
            if (ld_req && !pld) n_ld++;
            if (pe_start) begin n_pe++; pe_cyc = cyc; end
            if (done) n_done++;
            if (error && !perr) err_cyc = cyc;
            ph = sfu_valid && !sfu_ready; pi = sfu_idx; ptl = sfu_tile;
            pld = ld_req; prst = rst; perr = error;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        obsq.delete(); xcyc.delete();
        n_ld = 0; n_pe = 0; n_vld = 0; n_done = 0; pe_cyc = 0; err_cyc = 0;
    endtask

    task automatic kick(input int n);
        @(posedge clk); #1; num_tiles = TW'(n); start = 1;
        @(posedge clk); #1; start = 0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                chk("busy_at_done", busy, 0);
                break;
            end
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
        @(negedge clk); #1;
        chk("done_pulse_1cyc", done, 0);
    endtask

    // dens < 0: keep caller-prepared bm[]; 0: empty tiles; else % per bit
    task automatic run_job(input int n, input int dens, input string tag);
        int dc;
        @(negedge clk); #1;
        clear_obs();
        expq.delete();
        for (int t = 0; t < n; t++) begin
            if (dens >= 0) begin
                for (int k = 0; k < IS; k++)
                    bm[t][k] = (dens > 0) && ($urandom_range(99) < dens);
                if ($urandom_range(3) == 0) bm[t] = '0;
            end
            for (int k = 0; k < IS; k++)
                if (bm[t][k]) expq.push_back({TW'(t), IW'(k)});
        end
        kick(n);
        @(negedge clk); #1;
        chk({tag, "_busy"}, busy, 1);
        wait_done(20000, dc);
        chk({tag, "_nld"}, n_ld, n);
        chk({tag, "_npe"}, n_pe, n);
        chk({tag, "_ndone"}, n_done, 1);
        chk({tag, "_nxfer"}, obsq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obsq.size(); i++)
            chk({tag, "_xfer"}, obsq[i], expq[i]);
        chk({tag, "_cnt"}, outlier_cnt, expq.size());
        chk({tag, "_err"}, error, 0);
    endtask

    initial begin
        int dc;
        rst = 1; start = 0; num_tiles = '0;
        for (int t = 0; t < 256; t++) bm[t] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_err", error, 0);   chk("rst_ldreq", ld_req, 0);
        chk("rst_pest", pe_start, 0); chk("rst_sfuv", sfu_valid, 0);
        chk("rst_ldt", ld_tile, 0); chk("rst_idx", sfu_idx, 0);
        chk("rst_sfut", sfu_tile, 0); chk("rst_cnt", outlier_cnt, 0);
        rst = 0;

        // 1: three empty tiles
        ld_delay = 2; pe_delay = 2; rdy_pct = 100;
        run_job(3, 0, "t1");
        chk("t1_nvld", n_vld, 0);

        // 2: bits {0,5,127} back to back
        bm[0] = '0; bm[0][5] = 1; bm[0][0] = 1; bm[0][127] = 1;
        run_job(1, -1, "t2");
        if (xcyc.size() == 3) begin
            chk("t2_b2b_a", xcyc[1] - xcyc[0], 1);
            chk("t2_b2b_b", xcyc[2] - xcyc[1], 1);
        end else chk("t2_nx", xcyc.size(), 3);

        // 3: bit 9 under 4 cycles of backpressure
        bm[0] = '0; bm[0][9] = 1; rdy_low = 4;
        run_job(1, -1, "t3");
        chk("t3_nvld", n_vld, 5);

        // 4: PE never answers
        @(negedge clk); #1;
        clear_obs(); pe_hang = 1;
        kick(3);
        wait_done(TO + 200, dc);
        chk("t4_err", error, 1);
        chk("t4_latency", err_cyc - pe_cyc, TO);
        chk("t4_done_cyc", dc, err_cyc);
        chk("t4_nld", n_ld, 1);
        chk("t4_npe", n_pe, 1);
        repeat (3) @(negedge clk);
        chk("t4_sticky", error, 1);
        pe_hang = 0;

        // 5: zero tiles, then start while busy
        @(negedge clk); #1;
        clear_obs();
        kick(0);
        @(negedge clk);
        chk("t5_done", done, 1);
        chk("t5_errclr", error, 0);
        @(negedge clk);
        chk("t5_done_off", done, 0);
        chk("t5_nld", n_ld, 0);
        @(negedge clk); #1;
        clear_obs(); pe_delay = 20; bm[0] = '0; bm[1] = '0;
        kick(2);
        kick(5);
        wait_done(2000, dc);
        chk("t5_ign_nld", n_ld, 2);
        chk("t5_ign_npe", n_pe, 2);
        pe_delay = 2;

        // 6: reset in the middle of dispatching tile 1
        @(negedge clk); #1;
        clear_obs();
        bm[0] = '0; bm[1] = '0; bm[1][39:0] = '1; bm[2] = '0; rdy_pct = 100;
        kick(3);
        dc = -1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sfu_valid) begin dc = k; break; end
        end
        if (dc < 0) chk("t6_vld_timeout", 0, 1);
        chk("t6_pre_tile", sfu_tile, 1);
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("t6_busy", busy, 0);   chk("t6_done", done, 0);
        chk("t6_err", error, 0);   chk("t6_ldreq", ld_req, 0);
        chk("t6_pest", pe_start, 0); chk("t6_sfuv", sfu_valid, 0);
        chk("t6_ldt", ld_tile, 0); chk("t6_idx", sfu_idx, 0);
        chk("t6_sfut", sfu_tile, 0); chk("t6_cnt", outlier_cnt, 0);
        repeat (4) @(negedge clk);
        chk("t6_nodone", n_done, 0);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            ld_delay = $urandom_range(3);
            pe_delay = $urandom_range(5);
            rdy_pct  = $urandom_range(100, 30);
            run_job($urandom_range(5, 1), $urandom_range(6), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
